tmr_writeback_voter: RTL and testbench
======================================

Name: tmr_writeback_voter

Overview:
- Registered majority voter that sits directly upstream of the lockstep recovery controller.
- Compares the writeback/retire bundles of the three redundant RISC-V cores each cycle.
- Forwards the majority bundle, including the retired instruction consumed as RD_Instr.
- Produces the 3-bit Voter_state that triggers rollback, tracks per-core consecutive disagreements, and permanently masks cores that fail repeatedly.

Parameters:
- DATA_W, 32, writeback data and instruction width.
- ADDR_W, 5, destination register index width.
- FAULT_THRESH, 4, consecutive minority votes before a core is masked (range 1..7).
- CNT_W, 3, width of the per-core disagreement counter.

Ports:
- clk  in  1  system clock.
- rst_in  in  1  reset; asynchronous and active-low.
- coreN_valid  in  1  core N retired an instruction this cycle (N = 0,1,2).
- coreN_wb_en  in  1  core N register write enable.
- coreN_rd  in  ADDR_W  core N destination register.
- coreN_wd  in  DATA_W  core N writeback data.
- coreN_instr  in  DATA_W  core N retired instruction word.
- recovery_active  in  1  lockstep controller is rolling back; freezes counters.
- fault_clear  in  1  synchronous clear of masks and counters.
- voted_valid  out  1  majority bundle valid.
- voted_wb_en  out  1  majority write enable.
- voted_rd  out  ADDR_W  majority destination register.
- voted_wd  out  DATA_W  majority writeback data.
- RD_Instr  out  DATA_W  majority retired instruction, forwarded to lockstep.
- Voter_state  out  3  bit N = 1 means core N agrees with the majority or is idle-agreeing.
- core_fault  out  3  sticky mask, bit N = core N excluded from voting.
- no_majority  out  1  one-cycle pulse when Voter_state = 000.

Behaviour:
- Compare vector per core: Vn = {valid, wb_en, rd, wd, instr}.
  - Equality is pairwise over the full vector.
  - Masked cores are excluded from all comparisons.
- Latency: all outputs are registered, one cycle after the input bundle.
- Reset (rst_in low, asynchronous):
  - All voted outputs are 0.
  - Voter_state = 111.
  - core_fault = 000; counters = 0; no_majority = 0.
  - Voter_state must never read 000 out of reset, so no spurious recovery is triggered.
- Idle cycle (no active core has valid = 1 and all active vectors are equal):
  - Voter_state = 111; voted_valid = 0.
  - Counters unchanged.
- Three active cores:
  - All equal: Voter_state = 111; outputs = V0.
  - Exactly one differs: that core's bit = 0, others = 1; outputs = the agreeing pair's vector.
  - All differ: Voter_state = 000; voted_* hold their previous values with voted_valid = 0; no_majority pulses.
- One core masked:
  - Remaining pair equal: Voter_state = 1s on the survivors, 0 on the masked bit; outputs = pair vector.
  - Remaining pair differs: Voter_state = 000 and the no-majority rules apply.
- Two cores masked:
  - Survivor passes through unchecked.
  - Voter_state = one-hot of the survivor; never 000.
- Three masked (only reachable through mis-configuration): Voter_state = 000 every cycle; voted_valid = 0.
- Disagreement counter per core (saturating at FAULT_THRESH):
  - +1 when the core is the minority in a 2-of-3 vote.
  - Cleared when the core agrees.
  - Unchanged on idle cycles, on Voter_state = 000, and while recovery_active = 1.
  - On reaching FAULT_THRESH, core_fault[N] is set the next cycle and stays set.
- fault_clear = 1:
  - Next edge clears core_fault and all counters.
  - Has priority over recovery_active and over a same-cycle counter increment.
  - The vote in that cycle still uses the pre-clear mask.
- recovery_active = 1: voting continues normally; only counters freeze.
- Reset asserted mid-vote aborts the pending result; the first post-reset output reflects reset values.

Decomposition:
- Shared package tmr_pkg:
  - VS_ALL_AGREE = 3'b111 and VS_NO_MAJORITY = 3'b000.
  - Compare-vector width = 2 + ADDR_W + 2*DATA_W.
  - Core index constants 0..2.
- One sub-module, tmr_fault_counter, instantiated 3x.
  - Inputs: inc, clr, freeze.
  - Output: saturating count and sticky fault bit.

Test Plan:
- Reset release with all cores idle -> Voter_state = 111, voted_valid = 0, core_fault = 000, no_majority never asserted.
- All cores retire instr 0x00A00093 (rd = 1, wd = 10) -> one cycle later voted_rd = 1, voted_wd = 10, RD_Instr = 0x00A00093, Voter_state = 111.
- Core1 wd = 11, cores 0/2 wd = 10 -> voted_wd = 10, Voter_state = 101; repeat 4 consecutive retires -> core_fault = 010 on the cycle after the 4th; then core1 garbage with cores 0/2 equal -> Voter_state = 101, counters unchanged.
- Cores wd = 10/11/12 -> Voter_state = 000 for one cycle, no_majority = 1, voted_wd holds its previous value, voted_valid = 0, counters unchanged.
- Core2 minority 3 times, then recovery_active = 1 with core2 still minority for 2 cycles -> counter stays at 3 and no fault; drop recovery_active, one more minority -> core_fault = 100.
- core_fault = 010 with fault_clear = 1 -> next cycle core_fault = 000 and counters = 0; rst_in pulsed low mid-stream -> outputs are reset values immediately (asynchronous).

Source files
------------

// File: rtl/tmr_pkg.sv
// Shared constants for the TMR writeback voter: Voter_state encodings,
// core indices and the width of the per-core compare vector.
package tmr_pkg;
  localparam logic [2:0] VS_ALL_AGREE   = 3'b111;
  localparam logic [2:0] VS_NO_MAJORITY = 3'b000;

  localparam logic [1:0] CORE0 = 2'd0;
  localparam logic [1:0] CORE1 = 2'd1;
  localparam logic [1:0] CORE2 = 2'd2;

  // {valid, wb_en, rd, wd, instr}
  function automatic int cmp_vec_w(input int addr_w, input int data_w);
    return 2 + addr_w + 2 * data_w;
  endfunction
endpackage

// File: rtl/tmr_fault_counter.sv
// Per-core saturating disagreement counter with a sticky fault bit that is
// raised the cycle after the count reaches FAULT_THRESH.
module tmr_fault_counter #(
  parameter int FAULT_THRESH = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             agree,
  input  logic             clr,
  input  logic             freeze,
  output logic [CNT_W-1:0] cnt,
  output logic             fault
);
  localparam logic [CNT_W-1:0] THRESH = CNT_W'(FAULT_THRESH);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             fault_d, fault_q;

  always_comb begin
    cnt_d   = cnt_q;
    fault_d = fault_q | (cnt_q >= THRESH);
    // clear wins over freeze and over a same-cycle increment
    if (clr) begin
      cnt_d   = '0;
      fault_d = 1'b0;
    end else if (!freeze) begin
      if (inc) begin
        if (cnt_q < THRESH) cnt_d = cnt_q + 1'b1;
      end else if (agree) begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign cnt   = cnt_q;
  assign fault = fault_q;
endmodule

// File: rtl/tmr_writeback_voter.sv
// Registered 2-of-3 majority voter over the writeback/retire bundles of three
// lockstep cores, with per-core fault tracking and sticky masking.
module tmr_writeback_voter
  import tmr_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int FAULT_THRESH = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              core0_valid,
  input  logic              core0_wb_en,
  input  logic [ADDR_W-1:0] core0_rd,
  input  logic [DATA_W-1:0] core0_wd,
  input  logic [DATA_W-1:0] core0_instr,
  input  logic              core1_valid,
  input  logic              core1_wb_en,
  input  logic [ADDR_W-1:0] core1_rd,
  input  logic [DATA_W-1:0] core1_wd,
  input  logic [DATA_W-1:0] core1_instr,
  input  logic              core2_valid,
  input  logic              core2_wb_en,
  input  logic [ADDR_W-1:0] core2_rd,
  input  logic [DATA_W-1:0] core2_wd,
  input  logic [DATA_W-1:0] core2_instr,
  input  logic              recovery_active,
  input  logic              fault_clear,
  output logic              voted_valid,
  output logic              voted_wb_en,
  output logic [ADDR_W-1:0] voted_rd,
  output logic [DATA_W-1:0] voted_wd,
  output logic [DATA_W-1:0] RD_Instr,
  output logic [2:0]        Voter_state,
  output logic [2:0]        core_fault,
  output logic              no_majority
);
  localparam int VW = cmp_vec_w(ADDR_W, DATA_W);

  logic [2:0][VW-1:0] vec;
  logic [VW-1:0]      sel;
  logic [1:0]         sel_idx;
  logic [2:0]         act, valid_in, inc, agree, fault_mask;
  logic               eq01, eq02, eq12, idle;

  logic              valid_d, valid_q, wb_en_d, wb_en_q, no_maj_d, no_maj_q;
  logic [ADDR_W-1:0] rd_d, rd_q;
  logic [DATA_W-1:0] wd_d, wd_q, instr_d, instr_q;
  logic [2:0]        vs_d, vs_q;

  assign vec[CORE0] = {core0_valid, core0_wb_en, core0_rd, core0_wd, core0_instr};
  assign vec[CORE1] = {core1_valid, core1_wb_en, core1_rd, core1_wd, core1_instr};
  assign vec[CORE2] = {core2_valid, core2_wb_en, core2_rd, core2_wd, core2_instr};
  assign valid_in   = {core2_valid, core1_valid, core0_valid};
  assign act        = ~fault_mask;
  assign eq01       = (vec[CORE0] == vec[CORE1]);
  assign eq02       = (vec[CORE0] == vec[CORE2]);
  assign eq12       = (vec[CORE1] == vec[CORE2]);

  always_comb begin
    vs_d    = VS_NO_MAJORITY;
    sel_idx = CORE0;
    inc     = '0;
    case (act)
      3'b111: begin
        if (eq01 && eq02) vs_d = VS_ALL_AGREE;
        else if (eq01) begin vs_d = 3'b011; inc = 3'b100; end
        else if (eq02) begin vs_d = 3'b101; inc = 3'b010; end
        else if (eq12) begin vs_d = 3'b110; inc = 3'b001; sel_idx = CORE1; end
      end
      3'b110:  if (eq12) begin vs_d = 3'b110; sel_idx = CORE1; end
      3'b101:  if (eq02) vs_d = 3'b101;
      3'b011:  if (eq01) vs_d = 3'b011;
      3'b100:  begin vs_d = 3'b100; sel_idx = CORE2; end
      3'b010:  begin vs_d = 3'b010; sel_idx = CORE1; end
      3'b001:  vs_d = 3'b001;
      default: ;
    endcase
    sel = vec[sel_idx];

    // every active core agrees but none retired: report all-agree, leave counters
    idle = (act != 3'b000) && (vs_d == act) && ((act & valid_in) == 3'b000);
    if (idle) begin
      vs_d = VS_ALL_AGREE;
      inc  = '0;
    end
    agree    = idle ? 3'b000 : (vs_d & act);
    no_maj_d = (vs_d == VS_NO_MAJORITY);

    if (no_maj_d) begin
      valid_d = 1'b0;
      wb_en_d = wb_en_q;
      rd_d    = rd_q;
      wd_d    = wd_q;
      instr_d = instr_q;
    end else begin
      valid_d = sel[VW-1];
      wb_en_d = sel[VW-2];
      rd_d    = sel[2*DATA_W +: ADDR_W];
      wd_d    = sel[DATA_W +: DATA_W];
      instr_d = sel[0 +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      valid_q  <= 1'b0;
      wb_en_q  <= 1'b0;
      rd_q     <= '0;
      wd_q     <= '0;
      instr_q  <= '0;
      vs_q     <= VS_ALL_AGREE;
      no_maj_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      wb_en_q  <= wb_en_d;
      rd_q     <= rd_d;
      wd_q     <= wd_d;
      instr_q  <= instr_d;
      vs_q     <= vs_d;
      no_maj_q <= no_maj_d;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_core
    tmr_fault_counter #(.FAULT_THRESH(FAULT_THRESH), .CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_in),
      .inc   (inc[i]),
      .agree (agree[i]),
      .clr   (fault_clear),
      .freeze(recovery_active),
      .cnt   (),
      .fault (fault_mask[i])
    );
  end

  assign voted_valid = valid_q;
  assign voted_wb_en = wb_en_q;
  assign voted_rd    = rd_q;
  assign voted_wd    = wd_q;
  assign RD_Instr    = instr_q;
  assign Voter_state = vs_q;
  assign core_fault  = fault_mask;
  assign no_majority = no_maj_q;
endmodule

// File: tb/tb_tmr_writeback_voter.sv
// Scoreboard bench for tmr_writeback_voter: a behavioural vote/fault model
// queues the expected bundle per driven cycle, popped one cycle later.
module tb_tmr_writeback_voter;
  typedef struct packed {
    logic        valid;
    logic        wb_en;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [31:0] instr;
  } core_t;

  typedef struct {
    logic [2:0] vs;
    logic       nm;
    logic [2:0] flt;
    core_t      o;
  } exp_t;

  logic clk = 1'b0;
  logic rst_in = 1'b0;
  logic rec = 1'b0, clr = 1'b0;
  core_t cin [3];

  logic        voted_valid, voted_wb_en, no_majority;
  logic [4:0]  voted_rd;
  logic [31:0] voted_wd, RD_Instr;
  logic [2:0]  Voter_state, core_fault;

  int checks = 0, errors = 0, stepno = 0;
  exp_t  sb[$];
  logic [2:0] m_fault;
  int    m_cnt [3];
  core_t m_out;

  localparam int THRESH = 4;
  localparam logic [31:0] ADDI = 32'h00A00093;

  always #5 clk = ~clk;

  tmr_writeback_voter dut (
    .clk(clk), .rst_in(rst_in),
    .core0_valid(cin[0].valid), .core0_wb_en(cin[0].wb_en), .core0_rd(cin[0].rd),
    .core0_wd(cin[0].wd), .core0_instr(cin[0].instr),
    .core1_valid(cin[1].valid), .core1_wb_en(cin[1].wb_en), .core1_rd(cin[1].rd),
    .core1_wd(cin[1].wd), .core1_instr(cin[1].instr),
    .core2_valid(cin[2].valid), .core2_wb_en(cin[2].wb_en), .core2_rd(cin[2].rd),
    .core2_wd(cin[2].wd), .core2_instr(cin[2].instr),
    .recovery_active(rec), .fault_clear(clr),
    .voted_valid(voted_valid), .voted_wb_en(voted_wb_en), .voted_rd(voted_rd),
    .voted_wd(voted_wd), .RD_Instr(RD_Instr), .Voter_state(Voter_state),
    .core_fault(core_fault), .no_majority(no_majority)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d got=%0h exp=%0h", tag, stepno, got, exp);
    end
  endtask

  function automatic core_t mk(input logic v, input logic [4:0] rd,
                               input logic [31:0] wd, input logic [31:0] ins);
    core_t c;
    c.valid = v; c.wb_en = v; c.rd = rd; c.wd = wd; c.instr = ins;
    return c;
  endfunction

  task automatic model_reset();
    m_fault = 3'b000;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    m_out = '0;
  endtask

  // Vote by counting, for each active core, how many active cores match it.
  task automatic model_push();
    exp_t e;
    int nact = 0, maj = -1;
    int agc [3];
    logic [2:0] actm, newf;
    logic anyv = 1'b0, idle;
    for (int i = 0; i < 3; i++) begin
      actm[i] = !m_fault[i];
      if (actm[i]) begin nact++; if (cin[i].valid) anyv = 1'b1; end
    end
    for (int i = 0; i < 3; i++) begin
      agc[i] = 0;
      for (int j = 0; j < 3; j++)
        if (actm[i] && actm[j] && cin[i] == cin[j]) agc[i]++;
    end
    for (int i = 2; i >= 0; i--) if (actm[i] && 2 * agc[i] > nact) maj = i;
    e.vs = 3'b000;
    if (maj >= 0)
      for (int i = 0; i < 3; i++) e.vs[i] = actm[i] && (cin[i] == cin[maj]);
    idle = (maj >= 0) && (e.vs == actm) && !anyv;
    if (idle) e.vs = 3'b111;
    e.nm = (e.vs == 3'b000);
    if (e.nm) begin e.o = m_out; e.o.valid = 1'b0; end
    else e.o = cin[maj];
    m_out = e.o;
    for (int i = 0; i < 3; i++) newf[i] = m_fault[i] | (m_cnt[i] >= THRESH);
    if (clr) begin
      newf = 3'b000;
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    end else if (!rec && !idle && maj >= 0) begin
      for (int i = 0; i < 3; i++)
        if (actm[i]) begin
          if (e.vs[i]) m_cnt[i] = 0;
          else if (nact == 3 && m_cnt[i] < THRESH) m_cnt[i]++;
        end
    end
    m_fault = newf;
    e.flt = newf;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    chk("vs", 64'(Voter_state), 64'(e.vs));
    chk("no_maj", 64'(no_majority), 64'(e.nm));
    chk("fault", 64'(core_fault), 64'(e.flt));
    chk("valid", 64'(voted_valid), 64'(e.o.valid));
    chk("wb_en", 64'(voted_wb_en), 64'(e.o.wb_en));
    chk("rd", 64'(voted_rd), 64'(e.o.rd));
    chk("wd", 64'(voted_wd), 64'(e.o.wd));
    chk("instr", 64'(RD_Instr), 64'(e.o.instr));
  endtask

  task automatic step(input core_t a, input core_t b, input core_t c,
                      input logic r, input logic fc);
    @(negedge clk);
    stepno++;
    cin[0] = a; cin[1] = b; cin[2] = c; rec = r; clr = fc;
    model_push();
    @(posedge clk);
    #1 compare_out();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_vs"}, 64'(Voter_state), 64'(3'b111));
    chk({tag, "_valid"}, 64'(voted_valid), 64'd0);
    chk({tag, "_wd"}, 64'(voted_wd), 64'd0);
    chk({tag, "_instr"}, 64'(RD_Instr), 64'd0);
    chk({tag, "_fault"}, 64'(core_fault), 64'd0);
    chk({tag, "_nm"}, 64'(no_majority), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    core_t z, g, w11, w12, g20, bad;
    z   = '0;
    g   = mk(1'b1, 5'd1, 32'd10, ADDI);
    w11 = mk(1'b1, 5'd1, 32'd11, ADDI);
    w12 = mk(1'b1, 5'd1, 32'd12, ADDI);
    g20 = mk(1'b1, 5'd2, 32'd20, 32'h01400113);
    bad = mk(1'b1, 5'd31, 32'hDEADBEEF, 32'hFFFFFFFF);
    for (int i = 0; i < 3; i++) cin[i] = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1 chk_reset_vals("in_reset");
    @(negedge clk) rst_in = 1'b1;

    // idle out of reset, then a clean retire
    step(z, z, z, 0, 0);
    step(z, z, z, 0, 0);
    step(g, g, g, 0, 0);

    // core1 minority until masked, then garbage on the masked core
    repeat (4) step(g, w11, g, 0, 0);
    step(g, bad, g, 0, 0);
    step(g, bad, g, 0, 0);
    step(g, bad, g, 0, 0);

    // fault_clear while masked, then a three-way split
    step(g, g, g, 0, 1);
    step(g, g, g, 0, 0);
    step(g, w11, w12, 0, 0);
    step(g20, g20, g20, 0, 0);

    // core2 minority, counters frozen during recovery, then masked
    repeat (3) step(g, g, w11, 0, 0);
    repeat (2) step(g, g, w11, 1, 0);
    step(g, g, w11, 0, 0);
    step(g, g, g, 0, 0);
    step(g20, g20, bad, 0, 0);
    step(g, w11, g, 0, 0);
    step(z, z, bad, 0, 0);

    // clear with recovery active at the same time
    step(g, g, g, 1, 1);
    step(g, g, w11, 0, 0);

    // reset mid-vote: pending result is discarded
    @(negedge clk);
    cin[0] = g20; cin[1] = g20; cin[2] = g20;
    #2 rst_in = 1'b0;
    #1 chk_reset_vals("async_rst");
    sb.delete();
    model_reset();
    @(posedge clk);
    #1 chk_reset_vals("held_rst");
    @(negedge clk) rst_in = 1'b1;
    step(g20, g20, g20, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
